ste_dac_tx: RTL and testbench
=============================

STE_DAC_TX -- requirements
Module: ste_dac_tx

Interface
REQ-001 Parameter DATA_W, 16, DAC word width; bits shifted per frame, MSB first.
REQ-002 Parameter CLK_DIV, 2, clk cycles per dac_sclk_o half-period; legal range 1..255.
REQ-003 Parameter GAP_CYC, 2, minimum clk cycles dac_sync_no stays high between frames; legal range 1..255.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 din_i  input  DATA_W  word to transmit; the averager's output.
REQ-007 din_vld_i  input  1  din_i valid.
REQ-008 din_rdy_o  output  1  block accepts din_i this cycle.
REQ-009 abort_i  input  1  synchronous frame abort.
REQ-010 dac_sclk_o  output  1  serial clock to DAC; idle low.
REQ-011 dac_sync_no  output  1  active-low frame select to DAC.
REQ-012 dac_sdo_o  output  1  serial data to DAC.
REQ-013 frame_done_o  output  1  one-cycle pulse at normal frame completion.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT and GAP.
REQ-015 din_rdy_o SHALL equal (state==IDLE) AND NOT abort_i.
REQ-016 A transfer SHALL be accepted when din_vld_i and din_rdy_o are both 1 on a clock edge; din_i is captured into the shift register on that edge.
REQ-017 On acceptance the state SHALL move to SHIFT, and on the next cycle dac_sync_no=0, dac_sdo_o=din_i[DATA_W-1] and dac_sclk_o=0.
REQ-018 In SHIFT, dac_sclk_o SHALL toggle every CLK_DIV cycles. Each bit therefore occupies 2*CLK_DIV cycles: CLK_DIV cycles low, then CLK_DIV cycles high.
REQ-019 The DAC samples on the sclk rising edge; dac_sdo_o SHALL change only together with the sclk falling transition, advancing to the next lower bit.
REQ-020 After DATA_W complete bit periods, i.e. 2*CLK_DIV*DATA_W cycles with dac_sync_no low, the block SHALL drive dac_sync_no=1, dac_sclk_o=0 and dac_sdo_o=0, pulse frame_done_o for one cycle, and enter GAP.
REQ-021 GAP SHALL last exactly GAP_CYC cycles and then return to IDLE; din_rdy_o stays 0 throughout SHIFT and GAP.
REQ-022 abort_i=1 in SHIFT SHALL, on the next cycle, give dac_sync_no=1, dac_sclk_o=0, dac_sdo_o=0 and state GAP, with no frame_done_o pulse.
REQ-023 abort_i in GAP SHALL restart the GAP count; abort_i in IDLE SHALL block acceptance only, so abort has priority over a simultaneous valid.
REQ-024 Minimum word period SHALL be 2*CLK_DIV*DATA_W + GAP_CYC + 1 cycles. Words presented while din_rdy_o=0 are held by the producer (valid/ready), never dropped internally.
REQ-025 dac_sclk_o, dac_sync_no, dac_sdo_o and frame_done_o SHALL be driven directly from flip-flops, with no glitches.
REQ-026 The bit counter SHALL be $clog2(DATA_W+1) bits wide and the divider counter 8 bits; neither may wrap inside a frame.

Reset
REQ-027 While reset_ni=0: state=IDLE, dac_sync_no=1, dac_sclk_o=0, dac_sdo_o=0, frame_done_o=0, shift register and counters 0; din_rdy_o=1 after release.
REQ-028 Reset asserted mid-frame SHALL end the frame immediately (sync high asynchronously), without a frame_done_o pulse.

Structure
REQ-029 The state enum typedef ste_dac_state_t (IDLE, SHIFT, GAP) SHALL live in the shared package ste_pkg.
REQ-030 The sclk divider/toggle logic SHALL be one sub-module, ste_sclk_gen (ports clk, reset_ni, en_i, div_i; outputs sclk_o, rise_o, fall_o).

Verification
REQ-031 Reset then idle 20 cycles -> sync_n=1, sclk=0, sdo=0, rdy=1 throughout.
REQ-032 DATA_W=16, CLK_DIV=2, GAP_CYC=2, din=16'hA5C3 accepted at cycle t -> sync_n low t+1..t+64, 16 rising edges, sampled bits = A5C3 MSB-first, frame_done pulse at t+65, rdy=1 again at t+67.
REQ-033 vld held high with 16'hFFFF then 16'h0001 back-to-back -> two frames, gap of exactly 2 cycles, second word sampled 0001, no word lost.
REQ-034 abort_i pulse at the 5th sclk rise of a frame -> sync_n high next cycle, no frame_done, GAP 2 cycles, next word transmits intact.
REQ-035 abort_i and din_vld_i both high in IDLE -> no acceptance, rdy=0 that cycle, word accepted the following cycle.
REQ-036 reset_ni low at cycle 30 of a frame -> sync_n=1 and sclk=0 asynchronously; after release the next accepted word transmits a full 16 bits.

Source files
------------

// File: rtl/ste_pkg.sv
// Shared types and constants for the STE DAC transmit path.
package ste_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ste_dac_state_t;

  localparam int DIV_W = 8;

endpackage

// File: rtl/ste_sclk_gen.sv
// Serial clock generator: holds sclk low while disabled, otherwise toggles every div_i cycles.
module ste_sclk_gen
  import ste_pkg::*;
(
  input  logic             clk,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             sclk_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [DIV_W-1:0] cnt;
  logic             terminal;

  // rise/fall flag the edge at which sclk_o is about to change level.
  assign terminal = en_i && (cnt == div_i - DIV_W'(1));
  assign rise_o   = terminal && !sclk_o;
  assign fall_o   = terminal && sclk_o;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt    <= '0;
      sclk_o <= 1'b0;
    end else if (!en_i) begin
      cnt    <= '0;
      sclk_o <= 1'b0;
    end else if (terminal) begin
      cnt    <= '0;
      sclk_o <= ~sclk_o;
    end else begin
      cnt    <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ste_dac_tx.sv
// Serial DAC transmitter: accepts a word over valid/ready and shifts it out MSB first
// under an active-low frame select, followed by an enforced inter-frame gap.
module ste_dac_tx
  import ste_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic [DATA_W-1:0] din_i,
  input  logic              din_vld_i,
  output logic              din_rdy_o,
  input  logic              abort_i,
  output logic              dac_sclk_o,
  output logic              dac_sync_no,
  output logic              dac_sdo_o,
  output logic              frame_done_o
);

  localparam int               BIT_W    = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV      = DIV_W'(CLK_DIV);
  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(DATA_W);

  ste_dac_state_t    state;
  logic [DATA_W-2:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [7:0]        gap_cnt;
  logic              accept;
  logic              sclk_en;
  logic              sclk_rise;
  logic              sclk_fall;

  assign din_rdy_o = (state == IDLE) && !abort_i;
  assign accept    = din_vld_i && din_rdy_o;
  // Dropping enable on an abort edge forces sclk low together with sync going high.
  assign sclk_en   = (state == SHIFT) && !abort_i;

  ste_sclk_gen u_sclk_gen (
    .clk      (clk),
    .reset_ni (reset_ni),
    .en_i     (sclk_en),
    .div_i    (DIV),
    .sclk_o   (dac_sclk_o),
    .rise_o   (sclk_rise),
    .fall_o   (sclk_fall)
  );

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      dac_sync_no  <= 1'b1;
      dac_sdo_o    <= 1'b0;
      frame_done_o <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SHIFT;
            dac_sync_no <= 1'b0;
            dac_sdo_o   <= din_i[DATA_W-1];
            shreg       <= din_i[DATA_W-2:0];
            bit_cnt     <= '0;
          end
        end
        SHIFT: begin
          if (abort_i) begin
            state       <= GAP;
            dac_sync_no <= 1'b1;
            dac_sdo_o   <= 1'b0;
            gap_cnt     <= '0;
          end else if (sclk_fall && (bit_cnt == BITS_ALL)) begin
            // Falling edge closing the last sampled bit ends the frame.
            state        <= GAP;
            dac_sync_no  <= 1'b1;
            dac_sdo_o    <= 1'b0;
            frame_done_o <= 1'b1;
            gap_cnt      <= '0;
          end else begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (sclk_fall) begin
              dac_sdo_o <= shreg[DATA_W-2];
              shreg     <= {shreg[DATA_W-3:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (abort_i) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ste_dac_tx.sv
// Self-checking bench for ste_dac_tx: directed scenarios plus random traffic against a
// timeline model derived from the frame timing rules.
module tb_ste_dac_tx;

  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 2;
  localparam int GAP_CYC = 2;
  localparam int FRAME   = 2 * CLK_DIV * DATA_W;

  logic              clk = 1'b0;
  logic              reset_ni = 1'b0;
  logic [DATA_W-1:0] din_i = '0;
  logic              din_vld_i = 1'b0;
  logic              din_rdy_o;
  logic              abort_i = 1'b0;
  logic              dac_sclk_o;
  logic              dac_sync_no;
  logic              dac_sdo_o;
  logic              frame_done_o;

  always #5 clk = ~clk;

  ste_dac_tx #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk          (clk),
    .reset_ni     (reset_ni),
    .din_i        (din_i),
    .din_vld_i    (din_vld_i),
    .din_rdy_o    (din_rdy_o),
    .abort_i      (abort_i),
    .dac_sclk_o   (dac_sclk_o),
    .dac_sync_no  (dac_sync_no),
    .dac_sdo_o    (dac_sdo_o),
    .frame_done_o (frame_done_o)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Reference timeline: accept cycle, last cycle with sync low, first cycle idle again.
  int          t_acc = -1000;
  int          shift_last = -1000;
  int          idle_at = 0;
  bit          aborted = 1'b1;
  logic [15:0] w_acc = '0;
  bit          last_acc = 1'b0;

  logic        prev_sclk = 1'b0;
  logic [15:0] cap = '0;
  int          rises = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic checkCycle();
    int   k;
    logic es, ec, ed, edone;
    if (n >= t_acc + 1 && n <= shift_last) begin
      k  = n - t_acc - 1;
      es = 1'b0;
      ec = ((k / CLK_DIV) % 2) == 1;
      ed = w_acc[DATA_W - 1 - k / (2 * CLK_DIV)];
    end else begin
      es = 1'b1;
      ec = 1'b0;
      ed = 1'b0;
    end
    edone = !aborted && (n == t_acc + FRAME + 1);
    checkOutput("sync_n", 32'(dac_sync_no), 32'(es));
    checkOutput("sclk", 32'(dac_sclk_o), 32'(ec));
    checkOutput("sdo", 32'(dac_sdo_o), 32'(ed));
    checkOutput("frame_done", 32'(frame_done_o), 32'(edone));
    if (!dac_sync_no && dac_sclk_o && !prev_sclk) begin
      cap = {cap[14:0], dac_sdo_o};
      rises++;
    end
    prev_sclk = dac_sclk_o;
    if (edone) begin
      checkOutput("frame_word", 32'(cap), 32'(w_acc));
      checkOutput("rise_count", 32'(rises), 32'(DATA_W));
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [15:0] d, input logic ab);
    logic mrdy;
    din_vld_i = vld;
    din_i     = d;
    abort_i   = ab;
    #1;
    mrdy = (n >= idle_at) && !ab;
    checkOutput("din_rdy", 32'(din_rdy_o), 32'(mrdy));
    last_acc = vld && mrdy;
    if (last_acc) begin
      t_acc      = n;
      w_acc      = d;
      shift_last = n + FRAME;
      idle_at    = n + FRAME + GAP_CYC + 1;
      aborted    = 1'b0;
      cap        = '0;
      rises      = 0;
    end else if (ab && n > t_acc && n <= shift_last) begin
      shift_last = n;
      aborted    = 1'b1;
      idle_at    = n + 1 + GAP_CYC;
    end else if (ab && n > shift_last && n < idle_at) begin
      idle_at = n + 1 + GAP_CYC;
    end
    @(posedge clk);
    #1;
    n++;
    checkCycle();
  endtask

  task automatic acceptWord(input logic [15:0] w);
    int guard;
    guard = 0;
    do begin
      applyStimulus(1'b1, w, 1'b0);
      guard++;
    end while (!last_acc && guard < 200);
    if (!last_acc) checkOutput("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    while (n < idle_at) applyStimulus(1'b0, 16'($urandom), 1'b0);
  endtask

  initial begin
    int guard;
    $display("[TB] starting");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sync_n", 32'(dac_sync_no), 32'(1));
    checkOutput("rst_sclk", 32'(dac_sclk_o), 32'(0));
    checkOutput("rst_sdo", 32'(dac_sdo_o), 32'(0));
    checkOutput("rst_done", 32'(frame_done_o), 32'(0));
    reset_ni = 1'b1;

    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 16'($urandom), 1'b0);

    $display("[TB] single word A5C3");
    acceptWord(16'hA5C3);
    drain();

    $display("[TB] back-to-back FFFF / 0001");
    acceptWord(16'hFFFF);
    acceptWord(16'h0001);
    drain();

    $display("[TB] abort at 5th sclk rise");
    acceptWord(16'($urandom));
    guard = 0;
    while (rises < 5 && guard < 100) begin
      applyStimulus(1'b0, 16'h0, 1'b0);
      guard++;
    end
    if (rises < 5) checkOutput("rise5_timeout", 32'(rises), 32'(5));
    applyStimulus(1'b0, 16'h0, 1'b1);
    drain();
    acceptWord(16'($urandom));
    drain();

    $display("[TB] abort with valid in idle");
    applyStimulus(1'b1, 16'h3C96, 1'b1);
    acceptWord(16'h3C96);
    drain();

    $display("[TB] reset mid-frame");
    acceptWord(16'($urandom));
    while (n < t_acc + 30) applyStimulus(1'b0, 16'h0, 1'b0);
    #3;
    reset_ni = 1'b0;
    #1;
    checkOutput("async_sync_n", 32'(dac_sync_no), 32'(1));
    checkOutput("async_sclk", 32'(dac_sclk_o), 32'(0));
    checkOutput("async_sdo", 32'(dac_sdo_o), 32'(0));
    @(posedge clk);
    #1;
    n++;
    checkOutput("rst_done_mid", 32'(frame_done_o), 32'(0));
    reset_ni   = 1'b1;
    t_acc      = -1000;
    shift_last = -1000;
    aborted    = 1'b1;
    idle_at    = n;
    prev_sclk  = 1'b0;
    acceptWord(16'($urandom));
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 24) == 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", n);
    $fatal(1, "[TB] watchdog");
  end

endmodule
